// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, redirect handling, sticky error HALT.
// Optional build macro INSTR_FETCH_ILLEGAL_CHECK_EN rejects words whose bits [1:0] != 2'b11.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_ce,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        fetch_err
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic        err_q, err_d;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    function automatic logic is_legal(input logic [31:0] word);
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
        return (word[1:0] == 2'b11);
`else
        return 1'b1;
`endif
    endfunction

    // Next-state logic: redirect outranks every other event outside HALT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        dpc_d   = dpc_q;
        err_d   = err_q;
        if (state_q != HALT && redirect_valid) begin
            if (!is_aligned(redirect_pc)) begin
                err_d   = 1'b1;
                state_d = HALT;
            end else begin
                pc_d = redirect_pc;
                // An in-flight read must still be absorbed before fetching again.
                if (state_q == WAIT || state_q == DRAIN) begin
                    state_d = mem_rvalid ? FETCH : DRAIN;
                end else begin
                    state_d = FETCH;
                end
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_gnt) begin
                        state_d = WAIT;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    if (!mem_rvalid) begin
                        state_d = WAIT;
                    end else if (is_legal(mem_rdata)) begin
                        instr_d = mem_rdata;
                        dpc_d   = pc_q;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            dpc_q   <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            err_q   <= err_d;
        end
    end

    // A same-cycle redirect must suppress both the request and the issue strobe.
    assign mem_req   = !rst && (state_q == FETCH) && !redirect_valid;
    assign mem_addr  = pc_q;
    assign dec_ce    = (state_q == ISSUE) && !stall && !redirect_valid;
    assign dec_instr = instr_q;
    assign dec_pc    = dpc_q;
    assign fetch_err = err_q;

endmodule
